// File: rtl/ifid_elastic_reg.sv
// IF/ID pipeline stage: DEPTH-entry elastic buffer between fetch and decode.
// Holds {pcp4, ins} pairs in a circular buffer with a valid/ready handshake.
// A synchronous flush empties the stage. While the stage is empty, decode sees
// a bubble: pcp4o=0 and the fields are sliced from NOP_INSN.
module ifid_elastic_reg #(
    parameter int          PC_W     = 32,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000,
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  pcp4,
    input  logic [31:0]      ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  pcp4o,
    output logic [5:0]       op,
    output logic [4:0]       rs_fmt,
    output logic [4:0]       rt_ft,
    output logic [4:0]       rd_fs,
    output logic [4:0]       sh_fd,
    output logic [5:0]       fun,
    output logic [15:0]      im,
    output logic [25:0]      ad,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]  mem_pc  [DEPTH];
    logic [31:0]      mem_ins [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_nxt, rd_nxt;
    logic [CNT_W-1:0] cnt;
    logic             push, pop;
    logic [31:0]      head_ins;
    logic [PC_W-1:0]  head_pc;

    // Handshake qualifiers and modulo-DEPTH pointer increments
    always_comb begin
        in_ready  = (cnt != CNT_W'(DEPTH));
        out_valid = (cnt != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        wr_nxt    = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rd_nxt    = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end

    // Pointer and occupancy state; flush overrides any push or pop this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            if (pop)  rd_ptr <= rd_nxt;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is applied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]  <= pcp4;
            mem_ins[wr_ptr] <= ins;
        end
    end

    // Head entry, or a bubble while empty, sliced into decode fields
    always_comb begin
        head_ins = out_valid ? mem_ins[rd_ptr] : NOP_INSN;
        head_pc  = out_valid ? mem_pc[rd_ptr]  : '0;
        pcp4o    = head_pc;
        op       = head_ins[31:26];
        rs_fmt   = head_ins[25:21];
        rt_ft    = head_ins[20:16];
        rd_fs    = head_ins[15:11];
        sh_fd    = head_ins[10:6];
        fun      = head_ins[5:0];
        im       = head_ins[15:0];
        ad       = head_ins[25:0];
        count    = cnt;
    end

endmodule

// File: tb/tb_ifid_elastic_reg.sv
// Bench for ifid_elastic_reg: a DEPTH=2 instance driven from a vector table,
// and a DEPTH=3 instance used for pointer wrap-around. A queue model holds the
// expected entries and is compared against the DUT head every cycle.
module tb_ifid_elastic_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance signals
    logic        iv2 = 0, fl2 = 0, or2 = 0;
    logic [31:0] pc2 = 0, ins2 = 0;
    logic        ir2, ov2;
    logic [31:0] pco2;
    logic [5:0]  op2, fu2;
    logic [4:0]  rs2, rt2, rd2, sh2;
    logic [15:0] im2;
    logic [25:0] ad2;
    logic [1:0]  cnt2;

    // DEPTH=3 instance signals
    logic        iv3 = 0, fl3 = 0, or3 = 0;
    logic [31:0] pc3 = 0, ins3 = 0;
    logic        ir3, ov3;
    logic [31:0] pco3;
    logic [5:0]  op3, fu3;
    logic [4:0]  rs3, rt3, rd3, sh3;
    logic [15:0] im3;
    logic [25:0] ad3;
    logic [1:0]  cnt3;

    ifid_elastic_reg #(.PC_W(32), .DEPTH(2), .NOP_INSN(NOP)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .pcp4(pc2), .ins(ins2),
        .flush(fl2), .out_valid(ov2), .out_ready(or2), .pcp4o(pco2), .op(op2),
        .rs_fmt(rs2), .rt_ft(rt2), .rd_fs(rd2), .sh_fd(sh2), .fun(fu2), .im(im2),
        .ad(ad2), .count(cnt2));

    ifid_elastic_reg #(.PC_W(32), .DEPTH(3), .NOP_INSN(NOP)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .pcp4(pc3), .ins(ins3),
        .flush(fl3), .out_valid(ov3), .out_ready(or3), .pcp4o(pco3), .op(op3),
        .rs_fmt(rs3), .rt_ft(rt3), .rd_fs(rd3), .sh_fd(sh3), .fun(fu3), .im(im3),
        .ad(ad3), .count(cnt3));

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        int          e_cnt;
        logic        e_ov;
        logic        e_ir;
    } vec_t;

    ent_t q2[$];
    ent_t q3[$];
    vec_t vt[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare the DEPTH=2 head against the model head (or a bubble)
    task automatic sb_check2();
        logic [31:0] ei, ep;
        if (q2.size() > 0) begin
            ei = q2[0].ins;
            ep = q2[0].pc;
            chk("d2 out_valid", ov2, 1);
        end else begin
            ei = NOP;
            ep = 0;
            chk("d2 out_valid", ov2, 0);
        end
        chk("d2 pcp4o", pco2, ep);
        chk("d2 op", op2, ei[31:26]);
        chk("d2 rs_fmt", rs2, ei[25:21]);
        chk("d2 rt_ft", rt2, ei[20:16]);
        chk("d2 rd_fs", rd2, ei[15:11]);
        chk("d2 sh_fd", sh2, ei[10:6]);
        chk("d2 fun", fu2, ei[5:0]);
        chk("d2 im", im2, ei[15:0]);
        chk("d2 ad", ad2, ei[25:0]);
        chk("d2 count", cnt2, q2.size());
        chk("d2 in_ready", ir2, q2.size() != 2);
    endtask

    // Called just after a negedge: drive, check the pre-edge head, update the model
    task automatic cyc2(input vec_t v);
        bit   push, pop;
        ent_t e;
        iv2 = v.iv; pc2 = v.pc; ins2 = v.ins; fl2 = v.fl; or2 = v.ordy;
        #1;
        sb_check2();
        push = v.iv && (q2.size() < 2) && !v.fl;
        pop  = (q2.size() > 0) && v.ordy && !v.fl;
        @(posedge clk);
        if (v.fl) begin
            q2.delete();
        end else begin
            if (pop) e = q2.pop_front();
            if (push) begin
                e.pc = v.pc; e.ins = v.ins;
                q2.push_back(e);
            end
        end
        @(negedge clk);
        iv2 = 0; fl2 = 0;
    endtask

    task automatic cyc3(input logic iv, input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        bit   push, pop;
        ent_t e;
        iv3 = iv; pc3 = pc; ins3 = ins; or3 = ordy;
        #1;
        if (q3.size() > 0) begin
            chk("d3 out_valid", ov3, 1);
            chk("d3 pcp4o", pco3, q3[0].pc);
            chk("d3 ins", {op3, ad3}, q3[0].ins);
        end else begin
            chk("d3 out_valid", ov3, 0);
            chk("d3 ins", {op3, ad3}, NOP);
        end
        chk("d3 count", cnt3, q3.size());
        chk("d3 in_ready", ir3, q3.size() != 3);
        push = iv && (q3.size() < 3);
        pop  = (q3.size() > 0) && ordy;
        @(posedge clk);
        if (pop) e = q3.pop_front();
        if (push) begin
            e.pc = pc; e.ins = ins;
            q3.push_back(e);
        end
        @(negedge clk);
        iv3 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //          iv  pc            ins           fl ordy cnt ov ir
        vt[0]  = '{1, 32'h0000_0004, 32'h012A_4020, 0, 1, 1, 1, 1};
        vt[1]  = '{1, 32'h0000_0008, 32'h0109_5020, 0, 1, 1, 1, 1};
        vt[2]  = '{1, 32'h0000_000C, 32'h014B_6022, 0, 1, 1, 1, 1};
        vt[3]  = '{0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 0, 1};
        vt[4]  = '{1, 32'h0000_0010, 32'h8C88_0004, 0, 0, 1, 1, 1};
        vt[5]  = '{1, 32'h0000_0014, 32'hAC88_0008, 0, 0, 2, 1, 0};
        vt[6]  = '{1, 32'h0000_0018, 32'h0232_8820, 0, 0, 2, 1, 0};
        vt[7]  = '{1, 32'h0000_0018, 32'h0232_8820, 0, 1, 1, 1, 1};
        vt[8]  = '{1, 32'h0000_0018, 32'h0232_8820, 0, 0, 2, 1, 0};
        vt[9]  = '{0, 32'h0000_0000, 32'h0000_0000, 0, 1, 1, 1, 1};
        vt[10] = '{1, 32'h0000_001C, 32'h3C01_1234, 0, 0, 2, 1, 0};
        vt[11] = '{1, 32'h0000_0020, 32'h0800_0040, 1, 1, 0, 0, 1};
        vt[12] = '{0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 0, 1};
        vt[13] = '{1, 32'h0000_0024, 32'h2129_FFFF, 0, 0, 1, 1, 1};

        // Reset state, during and after reset
        repeat (2) @(negedge clk);
        chk("rst out_valid", ov2, 0);
        chk("rst count", cnt2, 0);
        chk("rst in_ready", ir2, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst out_valid", ov2, 0);
        chk("post-rst count", cnt2, 0);
        chk("post-rst in_ready", ir2, 1);
        chk("post-rst op", op2, 0);
        chk("post-rst fun", fu2, 0);
        chk("post-rst pcp4o", pco2, 0);

        for (int i = 0; i < 14; i++) begin
            if (i == 7) begin
                chk("full head op", op2, 6'h23);
                chk("full head im", im2, 16'h0004);
            end
            cyc2(vt[i]);
            chk($sformatf("vec%0d count", i), cnt2, vt[i].e_cnt);
            chk($sformatf("vec%0d out_valid", i), ov2, vt[i].e_ov);
            chk($sformatf("vec%0d in_ready", i), ir2, vt[i].e_ir);
            if (i == 0) begin
                chk("add op", op2, 6'h00);
                chk("add rs", rs2, 5'd9);
                chk("add rt", rt2, 5'd10);
                chk("add rd", rd2, 5'd8);
                chk("add sh", sh2, 5'd0);
                chk("add fun", fu2, 6'h20);
                chk("add pcp4o", pco2, 32'h4);
            end
            if (i == 7) begin
                chk("second head op", op2, 6'h2B);
                chk("second head im", im2, 16'h0008);
            end
            if (i == 11) begin
                chk("flush ins", {op2, ad2}, NOP);
                chk("flush pcp4o", pco2, 0);
            end
        end

        // Async reset between edges while count=1
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", ov2, 0);
        chk("async rst count", cnt2, 0);
        chk("async rst in_ready", ir2, 1);
        chk("async rst pcp4o", pco2, 0);
        q2.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1, 32'h0000_0100, 32'h8C01_0010, 0, 1, 0, 0, 0};
        cyc2(v);
        v = '{1, 32'h0000_0104, 32'hAC02_0014, 0, 0, 0, 0, 0};
        cyc2(v);
        v = '{0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 0, 0};
        cyc2(v);
        cyc2(v);
        cyc2(v);

        // DEPTH=3 wrap-around: fill two, stream seven push/pop pairs, drain
        cyc3(1, 32'h200, 32'h2000_0000, 0);
        cyc3(1, 32'h204, 32'h2000_0001, 0);
        for (int k = 2; k < 9; k++)
            cyc3(1, 32'h200 + 32'(4 * k), 32'h2000_0000 | 32'(k), 1);
        for (int k = 0; k < 4; k++)
            cyc3(0, 32'h0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
